// File: rtl/spi_pkg.sv
// Shared SPI slave definitions: command-FSM state encodings, address-generator
// FSM states and a constant log2 helper used for parameter-derived widths.
package spi_pkg;

    localparam logic [2:0] SPI_CMD     = 3'b000;
    localparam logic [2:0] SPI_ADDR_HB = 3'b001;
    localparam logic [2:0] SPI_ADDR_LB = 3'b011;
    localparam logic [2:0] SPI_BYTE_WR = 3'b010;
    localparam logic [2:0] SPI_PAGE_WR = 3'b110;
    localparam logic [2:0] SPI_DAT_RD  = 3'b111;
    localparam logic [2:0] SPI_WAIT    = 3'b101;
    localparam logic [2:0] SPI_ERR     = 3'b100;

    typedef enum logic [1:0] {
        A_IDLE   = 2'b00,
        A_LOAD   = 2'b01,
        A_ACTIVE = 2'b10
    } afsm_t;

    // Ceiling log2 for constant width calculations (clog2(1) = 0).
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int p = 1; p < value; p = p * 2) begin
            res = res + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/spi_addr_inc.sv
// Combinational address increment. Read mode counts linearly over the whole
// address space; write mode only advances the page offset and keeps the page.
module spi_addr_inc #(
    parameter int ADDR_W = 16,
    parameter int PAGE_W = 7
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              rd_mode,
    output logic [ADDR_W-1:0] next_addr,
    output logic              page_wrap,
    output logic              addr_ovf
);

    localparam logic [ADDR_W-1:0] PAGE_MASK = ADDR_W'((64'd1 << PAGE_W) - 64'd1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(32'd1);

    logic [ADDR_W-1:0] addr_inc_s;

    // Select linear or page-wrapped successor and flag the wrap event.
    always_comb begin
        addr_inc_s = addr + ADDR_ONE;
        if (rd_mode) begin
            next_addr = addr_inc_s;
            page_wrap = 1'b0;
            addr_ovf  = &addr;
        end else begin
            next_addr = (addr & ~PAGE_MASK) | (addr_inc_s & PAGE_MASK);
            page_wrap = ((addr & PAGE_MASK) == PAGE_MASK);
            addr_ovf  = 1'b0;
        end
    end

endmodule

// File: rtl/spi_addr_gen_pm.sv
// SPI serial-EEPROM address generator: shifts the address in MSB-first during
// the address states, then steps it once per data byte (linear on read,
// page-wrapped on write), skipping ECC slots when ECC is off.
module spi_addr_gen_pm
    import spi_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int PAGE_W  = 7,
    parameter int ECC_GRP = 4,
    parameter int ALIGN_B = 2
) (
    input  logic                      spi_clk_c,
    input  logic                      spi_frm_rst_n,
    input  logic                      sda_in,
    input  logic [2:0]                spi_curr_state,
    input  logic [2:0]                spi_bit_cnt,
    input  logic                      spi_ecc_en,
    input  logic                      spi_addr_keep,
    output logic [ADDR_W-1:0]         spi_curr_addr,
    output logic                      spi_addr_done,
    output logic                      spi_page_wrap,
    output logic                      spi_addr_ovf,
    output logic [clog2(ECC_GRP)-1:0] spi_grp_cnt
);

    localparam int                GRP_W    = clog2(ECC_GRP);
    localparam logic [GRP_W-1:0]  GRP_LAST = GRP_W'(ECC_GRP - 1);
    localparam logic [GRP_W-1:0]  GRP_ONE  = GRP_W'(32'd1);

    afsm_t              fsm_r, fsm_nxt_s;
    logic [ADDR_W-1:0]  addr_r, addr_nxt_s;
    logic               done_r, done_nxt_s;
    logic               wrap_r, wrap_nxt_s;
    logic               ovf_r, ovf_nxt_s;
    logic [GRP_W-1:0]   grp_r, grp_nxt_s;

    logic               load_s, load_last_s, data_s, byte_end_s;
    logic               rd_mode_s, align_zero_s, shift_bit_s;
    logic               enter_load_s, inc_s;
    logic [ADDR_W-1:0]  inc_addr_s;
    logic               inc_wrap_s, inc_ovf_s;

    spi_addr_inc #(
        .ADDR_W (ADDR_W),
        .PAGE_W (PAGE_W)
    ) u_inc (
        .addr      (addr_r),
        .rd_mode   (rd_mode_s),
        .next_addr (inc_addr_s),
        .page_wrap (inc_wrap_s),
        .addr_ovf  (inc_ovf_s)
    );

    // Decode the command-FSM state into load / data-byte qualifiers.
    always_comb begin
        load_s       = (spi_curr_state == SPI_ADDR_HB) || (spi_curr_state == SPI_ADDR_LB);
        load_last_s  = (spi_curr_state == SPI_ADDR_LB) && (spi_bit_cnt == 3'd0);
        rd_mode_s    = (spi_curr_state == SPI_DAT_RD);
        data_s       = (spi_curr_state == SPI_BYTE_WR) || (spi_curr_state == SPI_PAGE_WR) || rd_mode_s;
        byte_end_s   = data_s && (spi_bit_cnt == 3'd0);
        align_zero_s = (spi_curr_state == SPI_ADDR_LB) && (32'(spi_bit_cnt) < ALIGN_B) && !spi_ecc_en;
        shift_bit_s  = align_zero_s ? 1'b0 : sda_in;
        // The ECC slot (last byte of a group) carries no address step unless ECC is on.
        inc_s        = byte_end_s && ((grp_r != GRP_LAST) || spi_ecc_en) && !spi_addr_keep;
        enter_load_s = ((fsm_r == A_IDLE) && load_s) ||
                       ((fsm_r == A_ACTIVE) && (spi_curr_state == SPI_ADDR_HB));
    end

    // Next-state logic for the address-generator FSM.
    always_comb begin
        fsm_nxt_s = fsm_r;
        case (fsm_r)
            A_IDLE: begin
                if (load_s) begin
                    fsm_nxt_s = A_LOAD;
                end else begin
                    fsm_nxt_s = A_IDLE;
                end
            end
            A_LOAD: begin
                if (load_last_s) begin
                    fsm_nxt_s = A_ACTIVE;
                end else begin
                    fsm_nxt_s = A_LOAD;
                end
            end
            A_ACTIVE: begin
                if (spi_curr_state == SPI_ADDR_HB) begin
                    fsm_nxt_s = A_LOAD;
                end else begin
                    fsm_nxt_s = A_ACTIVE;
                end
            end
            default: fsm_nxt_s = A_IDLE;
        endcase
    end

    // Next address, pulse flags and ECC group index.
    always_comb begin
        addr_nxt_s = addr_r;
        done_nxt_s = 1'b0;
        wrap_nxt_s = 1'b0;
        ovf_nxt_s  = 1'b0;
        grp_nxt_s  = grp_r;
        if (load_s) begin
            addr_nxt_s = {addr_r[ADDR_W-2:0], shift_bit_s};
            done_nxt_s = load_last_s;
        end else if (inc_s) begin
            addr_nxt_s = inc_addr_s;
            wrap_nxt_s = inc_wrap_s;
            ovf_nxt_s  = inc_ovf_s;
        end else begin
            addr_nxt_s = addr_r;
        end
        if (enter_load_s) begin
            grp_nxt_s = {GRP_W{1'b0}};
        end else if (byte_end_s) begin
            grp_nxt_s = grp_r + GRP_ONE;
        end else begin
            grp_nxt_s = grp_r;
        end
    end

    // State and output registers; frame reset clears everything at once.
    always_ff @(posedge spi_clk_c or negedge spi_frm_rst_n) begin
        if (!spi_frm_rst_n) begin
            fsm_r  <= A_IDLE;
            addr_r <= {ADDR_W{1'b0}};
            done_r <= 1'b0;
            wrap_r <= 1'b0;
            ovf_r  <= 1'b0;
            grp_r  <= {GRP_W{1'b0}};
        end else begin
            fsm_r  <= fsm_nxt_s;
            addr_r <= addr_nxt_s;
            done_r <= done_nxt_s;
            wrap_r <= wrap_nxt_s;
            ovf_r  <= ovf_nxt_s;
            grp_r  <= grp_nxt_s;
        end
    end

    assign spi_curr_addr = addr_r;
    assign spi_addr_done = done_r;
    assign spi_page_wrap = wrap_r;
    assign spi_addr_ovf  = ovf_r;
    assign spi_grp_cnt   = grp_r;

endmodule

// File: tb/tb_spi_addr_gen_pm.sv
// Scoreboard bench for spi_addr_gen_pm: the driver pushes expected snapshots,
// a monitor compares them whenever the DUT presents an observable event.
module tb_spi_addr_gen_pm;
    import spi_pkg::*;

    typedef struct {
        logic [15:0] addr;
        logic        done;
        logic        wrap;
        logic        ovf;
        logic [1:0]  grp;
        logic [1:0]  fsm;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sda = 1'b0;
    logic [2:0]  curr_state = SPI_CMD;
    logic [2:0]  bit_cnt = 3'd7;
    logic        ecc_en = 1'b1;
    logic        addr_keep = 1'b0;
    logic [15:0] curr_addr;
    logic        addr_done;
    logic        page_wrap;
    logic        addr_ovf;
    logic [1:0]  grp_cnt;

    logic        snap = 1'b0;
    logic        finish_req = 1'b0;
    logic        prev_byte_end = 1'b0;

    exp_t        exp_q[$];
    string       name_q[$];
    int          total = 0;
    int          bad = 0;

    spi_addr_gen_pm #(
        .ADDR_W  (16),
        .PAGE_W  (7),
        .ECC_GRP (4),
        .ALIGN_B (2)
    ) dut (
        .spi_clk_c      (clk),
        .spi_frm_rst_n  (rst_n),
        .sda_in         (sda),
        .spi_curr_state (curr_state),
        .spi_bit_cnt    (bit_cnt),
        .spi_ecc_en     (ecc_en),
        .spi_addr_keep  (addr_keep),
        .spi_curr_addr  (curr_addr),
        .spi_addr_done  (addr_done),
        .spi_page_wrap  (page_wrap),
        .spi_addr_ovf   (addr_ovf),
        .spi_grp_cnt    (grp_cnt)
    );

    always #5 clk = ~clk;

    task automatic cyc(input logic [2:0] st, input logic [2:0] bc, input logic d);
        curr_state = st;
        bit_cnt    = bc;
        sda        = d;
        @(posedge clk);
        #1;
    endtask

    task automatic shift_byte(input logic [2:0] st, input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            cyc(st, 3'(i), b[i]);
        end
    endtask

    task automatic expect_obs(input string nm, input logic [15:0] a, input logic d,
                              input logic w, input logic o, input logic [1:0] g,
                              input logic [1:0] f);
        exp_t e;
        e.addr = a; e.done = d; e.wrap = w; e.ovf = o; e.grp = g; e.fsm = f;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic snap_check(input string nm, input logic [15:0] a, input logic [1:0] g,
                              input logic [1:0] f);
        expect_obs(nm, a, 1'b0, 1'b0, 1'b0, g, f);
        snap = 1'b1;
        @(negedge clk);
        #1;
        snap = 1'b0;
    endtask

    task automatic load_addr(input string nm, input logic [7:0] hb, input logic [7:0] lb,
                             input logic [15:0] a);
        expect_obs(nm, a, 1'b1, 1'b0, 1'b0, 2'd0, A_ACTIVE);
        shift_byte(SPI_ADDR_HB, hb);
        shift_byte(SPI_ADDR_LB, lb);
        cyc(SPI_WAIT, 3'd7, 1'b0);
    endtask

    task automatic data_byte(input string nm, input logic [2:0] st, input logic [15:0] a,
                             input logic w, input logic o, input logic [1:0] g);
        expect_obs(nm, a, 1'b0, w, o, g, A_ACTIVE);
        shift_byte(st, 8'h5A);
    endtask

    // Monitor: note data-byte ends as the DUT samples them.
    initial begin
        forever begin
            @(posedge clk);
            prev_byte_end = ((curr_state == SPI_BYTE_WR) || (curr_state == SPI_PAGE_WR) ||
                             (curr_state == SPI_DAT_RD)) && (bit_cnt == 3'd0);
        end
    end

    // Monitor: compare at observation points, otherwise require quiet pulses.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(negedge clk);
            if (finish_req) begin
                total++;
                if (exp_q.size() != 0) begin
                    bad++;
                    $display("FAIL leftover: pending=%0d required 0", exp_q.size());
                end
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end else if (snap || addr_done || prev_byte_end) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_obs: addr=%h done=%b required no event", curr_addr, addr_done);
                end else begin
                    e  = exp_q.pop_front();
                    nm = name_q.pop_front();
                    if (curr_addr !== e.addr || addr_done !== e.done || page_wrap !== e.wrap ||
                        addr_ovf !== e.ovf || grp_cnt !== e.grp || dut.fsm_r !== e.fsm) begin
                        bad++;
                        $display("FAIL %s: got addr=%h done=%b wrap=%b ovf=%b grp=%0d fsm=%0d, want addr=%h done=%b wrap=%b ovf=%b grp=%0d fsm=%0d",
                                 nm, curr_addr, addr_done, page_wrap, addr_ovf, grp_cnt, dut.fsm_r,
                                 e.addr, e.done, e.wrap, e.ovf, e.grp, e.fsm);
                    end
                end
            end else begin
                total++;
                if ({addr_done, page_wrap, addr_ovf} !== 3'b000) begin
                    bad++;
                    $display("FAIL quiet: got done=%b wrap=%b ovf=%b required 000", addr_done, page_wrap, addr_ovf);
                end
            end
        end
    end

    // Driver: directed scenarios.
    initial begin
        repeat (2) @(posedge clk);
        #1;
        snap_check("reset", 16'h0000, 2'd0, A_IDLE);
        rst_n = 1'b1;
        cyc(SPI_CMD, 3'd7, 1'b0);

        // Load with ECC on: no alignment.
        ecc_en = 1'b1;
        load_addr("load_ecc", 8'h12, 8'h34, 16'h1234);

        // Re-address with ECC off: two LSBs forced to zero.
        ecc_en = 1'b0;
        load_addr("load_align", 8'h12, 8'h37, 16'h1234);

        // Linear read with ECC-slot skipping.
        data_byte("rd0", SPI_DAT_RD, 16'h1235, 1'b0, 1'b0, 2'd1);
        data_byte("rd1", SPI_DAT_RD, 16'h1236, 1'b0, 1'b0, 2'd2);
        data_byte("rd2", SPI_DAT_RD, 16'h1237, 1'b0, 1'b0, 2'd3);
        data_byte("rd3_slot", SPI_DAT_RD, 16'h1237, 1'b0, 1'b0, 2'd0);
        data_byte("rd4", SPI_DAT_RD, 16'h1238, 1'b0, 1'b0, 2'd1);
        data_byte("rd5", SPI_DAT_RD, 16'h1239, 1'b0, 1'b0, 2'd2);
        data_byte("rd6", SPI_DAT_RD, 16'h123A, 1'b0, 1'b0, 2'd3);
        data_byte("rd7_slot", SPI_DAT_RD, 16'h123A, 1'b0, 1'b0, 2'd0);
        cyc(SPI_WAIT, 3'd7, 1'b0);

        // Page write wraps offset inside the page.
        ecc_en = 1'b1;
        load_addr("load_fe", 8'h00, 8'hFE, 16'h00FE);
        data_byte("wr0", SPI_PAGE_WR, 16'h00FF, 1'b0, 1'b0, 2'd1);
        data_byte("wr1_wrap", SPI_PAGE_WR, 16'h0080, 1'b1, 1'b0, 2'd2);
        data_byte("wr2", SPI_PAGE_WR, 16'h0081, 1'b0, 1'b0, 2'd3);
        cyc(SPI_WAIT, 3'd7, 1'b0);

        // Read overflow, then address keep.
        load_addr("load_ffff", 8'hFF, 8'hFF, 16'hFFFF);
        data_byte("rd_ovf", SPI_DAT_RD, 16'h0000, 1'b0, 1'b1, 2'd1);
        addr_keep = 1'b1;
        data_byte("rd_keep", SPI_DAT_RD, 16'h0000, 1'b0, 1'b0, 2'd2);
        addr_keep = 1'b0;
        cyc(SPI_WAIT, 3'd0, 1'b1);
        cyc(SPI_ERR, 3'd0, 1'b1);
        cyc(SPI_CMD, 3'd0, 1'b1);
        snap_check("hold_idle_states", 16'h0000, 2'd2, A_ACTIVE);

        // Frame reset in the middle of the low address byte.
        shift_byte(SPI_ADDR_HB, 8'hAB);
        for (int i = 7; i >= 4; i--) begin
            cyc(SPI_ADDR_LB, 3'(i), 1'b1);
        end
        #2;
        rst_n = 1'b0;
        snap_check("rst_mid_load", 16'h0000, 2'd0, A_IDLE);
        cyc(SPI_CMD, 3'd7, 1'b0);
        cyc(SPI_CMD, 3'd7, 1'b0);
        rst_n = 1'b1;
        cyc(SPI_CMD, 3'd7, 1'b0);
        load_addr("reload", 8'h56, 8'h78, 16'h5678);
        cyc(SPI_CMD, 3'd7, 1'b0);

        finish_req = 1'b1;
        repeat (5) @(posedge clk);
        $display("FAIL finish_timeout: monitor did not end the run");
        $fatal(1);
    end

endmodule
